// File: rtl/rr_sel_arbiter.sv
// Round-robin 4:1 mux select arbiter. Each grant is held until the owner
// sends done, withdraws its request, or uses up TIMEOUT cycles.
module rr_sel_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] sel,
  output logic [3:0] gnt,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] last_q, last_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] gnt_q, gnt_d;
  logic       busy_q, busy_d;
  logic       timeout_q, timeout_d;

  logic [1:0] win;
  logic [1:0] idx;
  logic       found;
  logic       limit;
  logic       owner_req;

  // Scan from last+1 upward; 2-bit arithmetic provides the 3->0 wrap.
  always_comb begin
    win   = last_q;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= 4; i++) begin
      idx = last_q + 2'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  assign limit     = (cnt_q == 8'(TIMEOUT - 1));
  assign owner_req = req[sel_q];

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        gnt_d  = '0;
        busy_d = 1'b0;
        cnt_d  = '0;
        if (found) begin
          sel_d   = win;
          last_d  = win;
          gnt_d   = 4'(1) << win;
          busy_d  = 1'b1;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (done || !owner_req || limit) begin
          state_d   = IDLE;
          busy_d    = 1'b0;
          gnt_d     = '0;
          cnt_d     = '0;
          // Pulse only when the counter alone forced the release.
          timeout_d = !done && owner_req && limit;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      last_q    <= 2'd3;
      cnt_q     <= '0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign sel     = sel_q;
  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule
